axi3_rd_sram_responder: RTL and testbench
=========================================

Name: axi3_rd_sram_responder

Overview:
- AXI3 read-channel responder: the slave end of the AXI3 read interface, driving the slave modport's outputs (axi3_rd_resp, rid) from its inputs (axi3_rd_req, arid).
- Serves read bursts from a synchronous, fixed-latency on-chip RAM/ROM port.
- Used as the boot ROM / scratchpad target on the SoC interconnect and as a memory model for I$/D$ refill benches.
- Handles one outstanding burst at a time; a small response FIFO absorbs rready backpressure.

Parameters:
- BUS_WIDTH, 4, width of arid/rid.
- ADDR_WIDTH, 14, RAM word-address width; capacity is 2^ADDR_WIDTH 32-bit words.
- BASE_ADDR, 32'h1fc0_0000, byte base address; must be aligned to 2^(ADDR_WIDTH+2).
- MEM_LATENCY, 1, cycles from mem_en to valid mem_rddata; legal range 1..3.
- FIFO_DEPTH, 4, response FIFO entries; must be >= MEM_LATENCY+2.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- arid  input  BUS_WIDTH  AR transaction id
- axi3_rd_req  input  $bits(axi3_rd_req_t)  ar* fields and rready
- rid  output  BUS_WIDTH  R id; equals the latched arid
- axi3_rd_resp  output  $bits(axi3_rd_resp_t)  arready, rdata, rresp, rlast, rvalid
- mem_en  output  1  RAM read strobe
- mem_addr  output  ADDR_WIDTH  RAM word address
- mem_rddata  input  32  RAM data, valid MEM_LATENCY cycles after mem_en

Behaviour:
- Interface decision: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: arready=0, rvalid=0, rlast=0, rresp=0, rdata=0, rid=0, mem_en=0, mem_addr=0. FIFO is emptied, in-flight RAM reads are discarded, FSM goes to IDLE.
- arready rises the first cycle after rst deasserts.
- Reset mid-burst: the same reset values apply on the next edge. No further beats are issued, and no rvalid appears for the aborted burst.
- FSM states are IDLE, BURST and ERR.
- IDLE: arready=1. On arvalid&&arready, latch arid, araddr, arlen, arsize and arburst, set beat counters to 0, drop arready, then classify the request:
  - arsize>2, arburst==2'b11, or arburst==WRAP with arlen not in {1,3,7,15} -> ERR with resp SLVERR (2'b10).
  - araddr[31:ADDR_WIDTH+2] != BASE_ADDR[31:ADDR_WIDTH+2] -> ERR with resp DECERR (2'b11).
  - Otherwise -> BURST.
- arlock, arcache and arprot are ignored.
- BURST, issue side:
  - Issue one read per cycle while issued<=arlen and (fifo_count+inflight)<FIFO_DEPTH.
  - mem_addr = cur_addr[ADDR_WIDTH+1:2].
  - Advance cur_addr after each issue:
    - FIXED: unchanged.
    - INCR: +(1<<arsize), 32-bit wrap.
    - WRAP: +(1<<arsize) within the block of size (arlen+1)<<arsize aligned to that size. Only the low bits below the block size wrap.
  - Data returning MEM_LATENCY cycles after issue is pushed into the FIFO at that clock edge.
- BURST, response side:
  - rvalid = FIFO non-empty; rdata = FIFO head; rresp = 2'b00.
  - rlast=1 exactly when beats_sent==arlen.
  - Pop on rvalid&&rready.
  - Data is byte-lane correct: the full word is returned, and sub-word arsize selects no lanes.
- ERR: no RAM access. rvalid=1 from the cycle after the AR handshake, rdata=0, rresp = latched error code. Emits arlen+1 beats, with rlast on the final beat.
- End of burst: on the handshake of the rlast beat, go to IDLE. arready=1 the next cycle, giving a minimum 1-cycle gap between bursts.
- Latency (BURST, rready held high): AR handshake in cycle T, mem_en in T+1, first rvalid in T+2+MEM_LATENCY.
- Throughput: with FIFO_DEPTH>=MEM_LATENCY+2 and rready held high, beats are back-to-back (one per cycle).
- rvalid, rdata, rlast, rresp and rid stay stable while rvalid&&!rready (AXI rule).
- The FIFO never overflows. Issue is credit-gated on fifo_count+inflight.
- Simultaneous push and pop on a full FIFO is impossible by construction; an assertion checks it.

Test Plan:
- Reset, then one INCR request: arid=3, araddr=0x1fc00010, arlen=3, arsize=2, RAM word i = i. Expect arready=1 after reset; rdata 4,5,6,7 with rid=3 and rresp=0; rlast only on beat 4; first rvalid at T+3; beats back-to-back.
- WRAP request: araddr=0x1fc00008, arlen=3, arsize=2 -> mem_addr sequence 2,3,0,1; rdata 2,3,0,1.
- Backpressure: INCR arlen=15, rready toggling 1,0,0,1... -> all 16 beats delivered in order with no loss or duplication; outputs stable while stalled; FIFO never exceeds FIFO_DEPTH.
- Errors:
  - arsize=3, arlen=2 -> 3 beats with rresp=2'b10, rdata=0, no mem_en pulses.
  - araddr=0x80000000 -> DECERR 2'b11 for arlen+1 beats.
  - arburst=WRAP with arlen=2 -> SLVERR.
- FIXED request: arlen=3, araddr=0x1fc00004 -> four beats, all rdata=1 (mem_addr held at 1).
- Reset mid-burst: assert rst after beat 2 of an 8-beat burst -> next cycle rvalid=0 and arready=0. After release, arready=1; a new burst returns correct data with no stale beats.

Source files
------------

// File: rtl/axi3_rd_sram_responder_if.sv
// rtl/axi3_rd_sram_responder_if.sv - AXI3 read-channel bundle (AR request fields, R response fields, ids)
interface axi3_rd_if #(
  parameter int BUS_WIDTH = 4
);

  typedef struct packed {
    logic        arvalid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        rready;
  } axi3_rd_req_t;

  typedef struct packed {
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
  } axi3_rd_resp_t;

  logic [BUS_WIDTH-1:0] arid;
  logic [BUS_WIDTH-1:0] rid;
  axi3_rd_req_t         axi3_rd_req;
  axi3_rd_resp_t        axi3_rd_resp;

  modport master (
    output arid,
    output axi3_rd_req,
    input  rid,
    input  axi3_rd_resp
  );

  modport slave (
    input  arid,
    input  axi3_rd_req,
    output rid,
    output axi3_rd_resp
  );

endinterface

// File: rtl/axi3_rd_sram_responder.sv
// rtl/axi3_rd_sram_responder.sv - AXI3 read responder serving bursts from a fixed-latency RAM port
module axi3_rd_sram_responder #(
  parameter int          BUS_WIDTH   = 4,
  parameter int          ADDR_WIDTH  = 14,
  parameter logic [31:0] BASE_ADDR   = 32'h1fc0_0000,
  parameter int          MEM_LATENCY = 1,
  parameter int          FIFO_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  axi3_rd_if.slave              bus,
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_rddata
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_ERR} state_t;

  state_t                 state_q, state_d;
  logic                   arready_q, arready_d;
  logic [BUS_WIDTH-1:0]   id_q, id_d;
  logic [31:0]            cur_addr_q, cur_addr_d;
  logic [3:0]             len_q, len_d;
  logic [2:0]             size_q, size_d;
  logic [1:0]             burst_q, burst_d;
  logic [1:0]             err_q, err_d;
  logic [4:0]             issued_q, issued_d;
  logic [4:0]             sent_q, sent_d;

  logic [MEM_LATENCY-1:0] pipe_q;
  logic [31:0]            fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]       fifo_cnt_q;

  logic        issue, push, pop;
  logic        rvalid, rlast;
  logic [1:0]  rresp;
  logic [31:0] rdata;
  logic [7:0]  inflight, used;
  logic [31:0] step, incr_addr, wrap_mask, next_addr;
  logic        slverr, decerr, wrap_len_ok;
  logic        unused_ok;

  // Sideband AR attributes carry no meaning for a plain RAM target.
  assign unused_ok = ^{bus.axi3_rd_req.arlock, bus.axi3_rd_req.arcache, bus.axi3_rd_req.arprot};

  assign push     = pipe_q[MEM_LATENCY-1];
  assign mem_en   = issue;
  assign mem_addr = cur_addr_q[ADDR_WIDTH+1:2];
  assign bus.rid  = id_q;
  assign bus.axi3_rd_resp = {arready_q, rdata, rresp, rlast, rvalid};

  // Credit accounting: reads still inside the RAM pipeline already own a FIFO slot.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < MEM_LATENCY; i++) begin
      inflight = inflight + {7'd0, pipe_q[i]};
    end
    used = 8'(fifo_cnt_q) + inflight;
  end

  // Next beat address; WRAP only rolls the bits below the aligned block size.
  always_comb begin
    step      = 32'd1 << size_q;
    incr_addr = cur_addr_q + step;
    wrap_mask = (({28'd0, len_q} + 32'd1) << size_q) - 32'd1;
    case (burst_q)
      BURST_INCR: next_addr = incr_addr;
      BURST_WRAP: next_addr = (cur_addr_q & ~wrap_mask) | (incr_addr & wrap_mask);
      default:    next_addr = cur_addr_q;
    endcase
  end

  // Request classification from the live AR fields.
  always_comb begin
    wrap_len_ok = (bus.axi3_rd_req.arlen == 4'd1) || (bus.axi3_rd_req.arlen == 4'd3) ||
                  (bus.axi3_rd_req.arlen == 4'd7) || (bus.axi3_rd_req.arlen == 4'd15);
    slverr = (bus.axi3_rd_req.arsize > 3'd2) || (bus.axi3_rd_req.arburst == 2'b11) ||
             ((bus.axi3_rd_req.arburst == BURST_WRAP) && !wrap_len_ok);
    decerr = bus.axi3_rd_req.araddr[31:ADDR_WIDTH+2] != BASE_ADDR[31:ADDR_WIDTH+2];
  end

  // FSM next state, RAM issue and R-channel outputs.
  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    cur_addr_d = cur_addr_q;
    len_d      = len_q;
    size_d     = size_q;
    burst_d    = burst_q;
    err_d      = err_q;
    issued_d   = issued_q;
    sent_d     = sent_q;
    issue      = 1'b0;
    pop        = 1'b0;
    rvalid     = 1'b0;
    rlast      = 1'b0;
    rresp      = 2'b00;
    rdata      = 32'd0;
    case (state_q)
      S_IDLE: begin
        if (bus.axi3_rd_req.arvalid && arready_q) begin
          id_d       = bus.arid;
          cur_addr_d = bus.axi3_rd_req.araddr;
          len_d      = bus.axi3_rd_req.arlen;
          size_d     = bus.axi3_rd_req.arsize;
          burst_d    = bus.axi3_rd_req.arburst;
          issued_d   = '0;
          sent_d     = '0;
          if (slverr) begin
            state_d = S_ERR;
            err_d   = 2'b10;
          end else if (decerr) begin
            state_d = S_ERR;
            err_d   = 2'b11;
          end else begin
            state_d = S_BURST;
          end
        end
      end
      S_BURST: begin
        issue = (issued_q <= {1'b0, len_q}) && (used < 8'(FIFO_DEPTH));
        if (issue) begin
          issued_d   = issued_q + 5'd1;
          cur_addr_d = next_addr;
        end
        rvalid = fifo_cnt_q != '0;
        rdata  = rvalid ? fifo_mem[rd_ptr_q] : 32'd0;
        rlast  = rvalid && (sent_q == {1'b0, len_q});
        pop    = rvalid && bus.axi3_rd_req.rready;
        if (pop) begin
          sent_d = sent_q + 5'd1;
          if (rlast) state_d = S_IDLE;
        end
      end
      S_ERR: begin
        rvalid = 1'b1;
        rresp  = err_q;
        rlast  = sent_q == {1'b0, len_q};
        if (bus.axi3_rd_req.rready) begin
          sent_d = sent_q + 5'd1;
          if (rlast) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    arready_d = (state_d == S_IDLE);
  end

  // Burst context and FSM state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      arready_q  <= 1'b0;
      id_q       <= '0;
      cur_addr_q <= '0;
      len_q      <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      err_q      <= '0;
      issued_q   <= '0;
      sent_q     <= '0;
    end else begin
      state_q    <= state_d;
      arready_q  <= arready_d;
      id_q       <= id_d;
      cur_addr_q <= cur_addr_d;
      len_q      <= len_d;
      size_q     <= size_d;
      burst_q    <= burst_d;
      err_q      <= err_d;
      issued_q   <= issued_d;
      sent_q     <= sent_d;
    end
  end

  // RAM latency tracker and response FIFO pointers; reset drops in-flight reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      pipe_q <= (pipe_q << 1) | MEM_LATENCY'(issue);
      if (push) wr_ptr_q <= (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  // Response FIFO storage; returning RAM data lands at the tail.
  always_ff @(posedge clk) begin
    if (!rst && push) fifo_mem[wr_ptr_q] <= mem_rddata;
  end

  // Credit gating must make a push into a full FIFO impossible.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(push && pop && (fifo_cnt_q == CNT_W'(FIFO_DEPTH))));
      assert (!(push && !pop && (fifo_cnt_q == CNT_W'(FIFO_DEPTH))));
    end
  end

endmodule

// File: tb/tb_axi3_rd_sram_responder.sv
// tb/tb_axi3_rd_sram_responder.sv - directed self-checking bench for axi3_rd_sram_responder
module tb_axi3_rd_sram_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_en;
  logic [13:0] mem_addr;
  logic [31:0] mem_rddata = 32'd0;

  axi3_rd_if #(.BUS_WIDTH(4)) bus();

  axi3_rd_sram_responder #(
    .BUS_WIDTH(4), .ADDR_WIDTH(14), .BASE_ADDR(32'h1fc0_0000), .MEM_LATENCY(1), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .mem_en(mem_en), .mem_addr(mem_addr), .mem_rddata(mem_rddata)
  );

  always #5 clk = ~clk;

  logic        arready_o, rvalid_o, rlast_o;
  logic [31:0] rdata_o;
  logic [1:0]  rresp_o;
  logic [3:0]  rid_o;
  assign {arready_o, rdata_o, rresp_o, rlast_o, rvalid_o} = bus.axi3_rd_resp;
  assign rid_o = bus.rid;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int t_hs, men_base, got, stall_bad, fifo_peak;
  int men_addr[$];
  int men_cyc[$];
  logic [31:0] obs_data [16];
  logic        obs_last [16];
  logic [1:0]  obs_resp [16];
  logic [3:0]  obs_id   [16];
  int          obs_cyc  [16];

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: word i holds i, one cycle of read latency.
  always @(posedge clk) if (mem_en === 1'b1) mem_rddata <= {18'd0, mem_addr};

  always @(negedge clk) begin
    if (mem_en === 1'b1) begin
      men_addr.push_back(int'(mem_addr));
      men_cyc.push_back(cyc);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, want finish");
    $fatal(1);
  end

  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int guard = 0;
    @(negedge clk);
    bus.axi3_rd_req.rready = 1'b0;
    while (arready_o !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    bus.arid                = id;
    bus.axi3_rd_req.araddr  = addr;
    bus.axi3_rd_req.arlen   = len;
    bus.axi3_rd_req.arsize  = size;
    bus.axi3_rd_req.arburst = burst;
    bus.axi3_rd_req.arvalid = 1'b1;
    t_hs     = cyc;
    men_base = men_addr.size();
  endtask

  task automatic collect_beats(input int n, input bit stall_mode);
    int guard = 0;
    int phase = 0;
    bit holding = 1'b0;
    logic [31:0] h_data;
    logic h_last;
    logic [1:0] h_resp;
    logic [3:0] h_id;
    got = 0;
    stall_bad = 0;
    fifo_peak = 0;
    while (got < n && guard < 400) begin
      @(negedge clk);
      guard++;
      bus.axi3_rd_req.arvalid = 1'b0;
      if (holding && (rvalid_o !== 1'b1 || rdata_o !== h_data || rlast_o !== h_last ||
                      rresp_o !== h_resp || rid_o !== h_id)) stall_bad++;
      holding = 1'b0;
      bus.axi3_rd_req.rready = stall_mode ? (phase % 3 == 0) : 1'b1;
      phase++;
      if (int'(dut.fifo_cnt_q) > fifo_peak) fifo_peak = int'(dut.fifo_cnt_q);
      if (rvalid_o === 1'b1) begin
        if (bus.axi3_rd_req.rready) begin
          obs_data[got] = rdata_o;
          obs_last[got] = rlast_o;
          obs_resp[got] = rresp_o;
          obs_id[got]   = rid_o;
          obs_cyc[got]  = cyc;
          got++;
        end else begin
          holding = 1'b1;
          h_data = rdata_o; h_last = rlast_o; h_resp = rresp_o; h_id = rid_o;
        end
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({arready_o, rvalid_o, rlast_o, rresp_o, rdata_o, rid_o, mem_en, mem_addr} !== 56'd0) begin
      errors++;
      $display("FAIL reset_values: got arready=%0b rvalid=%0b rlast=%0b rresp=%0d rdata=%0h rid=%0d mem_en=%0b mem_addr=%0h want all 0",
               arready_o, rvalid_o, rlast_o, rresp_o, rdata_o, rid_o, mem_en, mem_addr);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (arready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_arready_rise: got %0b want 1", arready_o);
    end
  endtask

  task automatic test_incr;
    send_ar(4'd3, 32'h1fc0_0010, 4'd3, 3'd2, 2'b01);
    collect_beats(4, 1'b0);
    checks++;
    if (got !== 4) begin errors++; $display("FAIL incr_count: got %0d want 4", got); end
    for (int i = 0; i < got; i++) begin
      checks++;
      if (obs_data[i] !== 32'(4 + i) || obs_last[i] !== (i == 3) || obs_resp[i] !== 2'b00 || obs_id[i] !== 4'd3) begin
        errors++;
        $display("FAIL incr_beat%0d: got data=%0d last=%0b resp=%0d id=%0d want data=%0d last=%0b resp=0 id=3",
                 i, obs_data[i], obs_last[i], obs_resp[i], obs_id[i], 4 + i, (i == 3));
      end
      checks++;
      if (obs_cyc[i] !== t_hs + 3 + i) begin
        errors++;
        $display("FAIL incr_timing%0d: got cycle %0d want %0d", i, obs_cyc[i], t_hs + 3 + i);
      end
    end
    checks++;
    if (men_addr.size() - men_base !== 4 || men_cyc[men_base] !== t_hs + 1) begin
      errors++;
      $display("FAIL incr_mem_en: got %0d reads first at %0d want 4 reads first at %0d",
               men_addr.size() - men_base, men_cyc[men_base], t_hs + 1);
    end
    @(negedge clk);
    checks++;
    if (rvalid_o !== 1'b0 || arready_o !== 1'b1) begin
      errors++;
      $display("FAIL incr_end: got rvalid=%0b arready=%0b want rvalid=0 arready=1", rvalid_o, arready_o);
    end
  endtask

  task automatic test_wrap;
    int exp_seq[4] = '{2, 3, 0, 1};
    send_ar(4'd4, 32'h1fc0_0008, 4'd3, 3'd2, 2'b10);
    collect_beats(4, 1'b0);
    checks++;
    if (got !== 4) begin errors++; $display("FAIL wrap_count: got %0d want 4", got); end
    for (int i = 0; i < got; i++) begin
      checks++;
      if (obs_data[i] !== 32'(exp_seq[i]) || men_addr[men_base + i] !== exp_seq[i] || obs_last[i] !== (i == 3)) begin
        errors++;
        $display("FAIL wrap_beat%0d: got data=%0d addr=%0d last=%0b want %0d/%0d/%0b",
                 i, obs_data[i], men_addr[men_base + i], obs_last[i], exp_seq[i], exp_seq[i], (i == 3));
      end
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    send_ar(4'd5, 32'h1fc0_0000, 4'd15, 3'd2, 2'b01);
    collect_beats(16, 1'b1);
    checks++;
    if (got !== 16) begin errors++; $display("FAIL bp_count: got %0d want 16", got); end
    for (int i = 0; i < got; i++) begin
      checks++;
      if (obs_data[i] !== 32'(i) || obs_last[i] !== (i == 15)) begin
        errors++;
        $display("FAIL bp_beat%0d: got data=%0d last=%0b want data=%0d last=%0b", i, obs_data[i], obs_last[i], i, (i == 15));
      end
    end
    checks++;
    if (stall_bad !== 0) begin errors++; $display("FAIL bp_stable: got %0d unstable stalls want 0", stall_bad); end
    checks++;
    if (fifo_peak > 4) begin errors++; $display("FAIL bp_fifo_bound: got peak %0d want <= 4", fifo_peak); end
    @(negedge clk);
    checks++;
    if (rvalid_o !== 1'b0) begin errors++; $display("FAIL bp_no_extra: got rvalid=%0b want 0", rvalid_o); end
  endtask

  task automatic test_errors;
    logic [3:0]  e_len  [3] = '{4'd2, 4'd1, 4'd2};
    logic [2:0]  e_size [3] = '{3'd3, 3'd2, 3'd2};
    logic [1:0]  e_bst  [3] = '{2'b01, 2'b01, 2'b10};
    logic [31:0] e_addr [3] = '{32'h1fc0_0000, 32'h8000_0000, 32'h1fc0_0000};
    logic [1:0]  e_resp [3] = '{2'b10, 2'b11, 2'b10};
    for (int k = 0; k < 3; k++) begin
      send_ar(4'(6 + k), e_addr[k], e_len[k], e_size[k], e_bst[k]);
      collect_beats(int'(e_len[k]) + 1, 1'b0);
      checks++;
      if (got !== int'(e_len[k]) + 1) begin
        errors++;
        $display("FAIL err%0d_count: got %0d want %0d", k, got, int'(e_len[k]) + 1);
      end
      for (int i = 0; i < got; i++) begin
        checks++;
        if (obs_data[i] !== 32'd0 || obs_resp[i] !== e_resp[k] || obs_last[i] !== (i == int'(e_len[k])) ||
            obs_id[i] !== 4'(6 + k) || obs_cyc[i] !== t_hs + 1 + i) begin
          errors++;
          $display("FAIL err%0d_beat%0d: got data=%0h resp=%0d last=%0b id=%0d cyc=%0d want 0/%0d/%0b/%0d/%0d",
                   k, i, obs_data[i], obs_resp[i], obs_last[i], obs_id[i], obs_cyc[i],
                   e_resp[k], (i == int'(e_len[k])), 6 + k, t_hs + 1 + i);
        end
      end
      @(negedge clk);
      checks++;
      if (men_addr.size() !== men_base || rvalid_o !== 1'b0) begin
        errors++;
        $display("FAIL err%0d_no_ram: got %0d reads rvalid=%0b want 0 reads rvalid=0", k, men_addr.size() - men_base, rvalid_o);
      end
    end
  endtask

  task automatic test_fixed;
    send_ar(4'd1, 32'h1fc0_0004, 4'd3, 3'd2, 2'b00);
    collect_beats(4, 1'b0);
    checks++;
    if (got !== 4) begin errors++; $display("FAIL fixed_count: got %0d want 4", got); end
    for (int i = 0; i < got; i++) begin
      checks++;
      if (obs_data[i] !== 32'd1 || men_addr[men_base + i] !== 1) begin
        errors++;
        $display("FAIL fixed_beat%0d: got data=%0d addr=%0d want 1/1", i, obs_data[i], men_addr[men_base + i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_burst;
    send_ar(4'd2, 32'h1fc0_0000, 4'd7, 3'd2, 2'b01);
    collect_beats(2, 1'b0);
    checks++;
    if (got !== 2 || obs_data[1] !== 32'd1) begin
      errors++;
      $display("FAIL midrst_pre: got %0d beats last data %0d want 2 beats data 1", got, obs_data[1]);
    end
    @(negedge clk);
    rst = 1'b1;
    bus.axi3_rd_req.rready = 1'b0;
    @(negedge clk);
    men_base = men_addr.size();
    checks++;
    if (rvalid_o !== 1'b0 || arready_o !== 1'b0 || mem_en !== 1'b0) begin
      errors++;
      $display("FAIL midrst_abort: got rvalid=%0b arready=%0b mem_en=%0b want 0/0/0", rvalid_o, arready_o, mem_en);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (arready_o !== 1'b1 || rvalid_o !== 1'b0 || men_addr.size() !== men_base) begin
      errors++;
      $display("FAIL midrst_release: got arready=%0b rvalid=%0b reads=%0d want 1/0/0", arready_o, rvalid_o, men_addr.size() - men_base);
    end
    send_ar(4'd9, 32'h1fc0_0020, 4'd1, 3'd2, 2'b01);
    collect_beats(2, 1'b0);
    checks++;
    if (got !== 2) begin errors++; $display("FAIL midrst_new_count: got %0d want 2", got); end
    for (int i = 0; i < got; i++) begin
      checks++;
      if (obs_data[i] !== 32'(8 + i) || obs_id[i] !== 4'd9 || obs_cyc[i] !== t_hs + 3 + i || obs_last[i] !== (i == 1)) begin
        errors++;
        $display("FAIL midrst_new_beat%0d: got data=%0d id=%0d cyc=%0d last=%0b want %0d/9/%0d/%0b",
                 i, obs_data[i], obs_id[i], obs_cyc[i], obs_last[i], 8 + i, t_hs + 3 + i, (i == 1));
      end
    end
    @(negedge clk);
  endtask

  initial begin
    bus.arid                = '0;
    bus.axi3_rd_req.arvalid = 1'b0;
    bus.axi3_rd_req.araddr  = '0;
    bus.axi3_rd_req.arlen   = '0;
    bus.axi3_rd_req.arsize  = '0;
    bus.axi3_rd_req.arburst = '0;
    bus.axi3_rd_req.arlock  = '0;
    bus.axi3_rd_req.arcache = '0;
    bus.axi3_rd_req.arprot  = '0;
    bus.axi3_rd_req.rready  = 1'b0;
    test_reset();
    test_incr();
    test_wrap();
    test_backpressure();
    test_errors();
    test_fixed();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
